// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer slice.
//   state_t       : sequencer state encoding
//   OP_*          : opcode values carried in the instruction word
//   instr_width() : instruction word width for a given register-field width
//   op_lsb()      : bit offset of the opcode field
//   dst_lsb()     : bit offset of the destination field (source sits at bit 0)
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T1    = 3'd1,
    ST_T2    = 3'd2,
    ST_T3    = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  function automatic int unsigned instr_width(input int unsigned rsw);
    return 2 + 2 * rsw;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned rsw);
    return 2 * rsw;
  endfunction

  function automatic int unsigned dst_lsb(input int unsigned rsw);
    return rsw;
  endfunction

endpackage

// File: rtl/cu_onehot_decoder.sv
// Index-to-one-hot decoder.
//   idx    : W-bit register index
//   en     : output is all-zero when low
//   onehot : N-bit one-hot vector; an idx >= N yields all-zero
module cu_onehot_decoder #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en && (idx == W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the register-bus datapath.
// Latches {opcode, dst, src} on Start in IDLE, then runs
// T1 (dst -> Y), T2 (src + Y through ALU into Z, waits on AluDone with an
// optional timeout), T3 (Z -> dst). A timeout goes through ABORT instead.
//   Clock, Reset          : rising-edge clock, synchronous active-high reset
//   Start, InstrWord      : instruction request and word (sampled in IDLE)
//   AluDone               : ALU result valid this cycle
//   RegIn, RegOut         : one-hot register load / bus-drive strobes
//   Add, Sub, Mul, Div    : ALU operation select
//   SelectY, Yin, Zin, Zout : Y-mux select, Y load, Z load, Z bus drive
//   Busy, Done, Error     : in-progress flag, write-back pulse, timeout pulse
//   Step                  : debug step index (0 IDLE, 1 T1, 2 T2, 3 T3/ABORT)
module control_sequencer
  import cu_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int RSW        = $clog2(NUM_REGS),
  parameter int WAIT_LIMIT = 15
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [2+2*RSW-1:0]   InstrWord,
  input  logic                 AluDone,
  output logic [NUM_REGS-1:0]  RegIn,
  output logic [NUM_REGS-1:0]  RegOut,
  output logic                 Add,
  output logic                 Sub,
  output logic                 Mul,
  output logic                 Div,
  output logic                 SelectY,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 Zout,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error,
  output logic [1:0]           Step
);

  localparam int unsigned IW   = instr_width(RSW);
  localparam int unsigned OPL  = op_lsb(RSW);
  localparam int unsigned DSTL = dst_lsb(RSW);

  localparam int CW  = ($clog2(WAIT_LIMIT + 1) < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam int LM1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
  // Counter holds the number of T2 cycles already spent, so the limit cycle
  // is the one where it equals WAIT_LIMIT-1.
  localparam logic [CW-1:0] LIMIT_LAST = CW'(LM1);

  state_t          state, state_nxt;
  logic [IW-1:0]   ir;
  logic [CW-1:0]   cnt;
  logic [1:0]      op;
  logic [RSW-1:0]  dst, src;
  logic            timeout;
  logic [RSW-1:0]  rout_idx;
  logic            rout_en, rin_en;

  assign op  = ir[OPL +: 2];
  assign dst = ir[DSTL +: RSW];
  assign src = ir[RSW-1:0];

  assign timeout = (WAIT_LIMIT != 0) && (cnt == LIMIT_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && Start) ir <= InstrWord;
      if (state == ST_T1) begin
        cnt <= '0;
      end else if (state == ST_T2 && !AluDone && cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rout_idx  = dst;
    rout_en   = 1'b0;
    rin_en    = 1'b0;
    Add       = 1'b0;
    Sub       = 1'b0;
    Mul       = 1'b0;
    Div       = 1'b0;
    SelectY   = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zout      = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    Step      = 2'd0;
    case (state)
      ST_IDLE: begin
        if (Start) state_nxt = ST_T1;
      end
      ST_T1: begin
        rout_en   = 1'b1;
        Yin       = 1'b1;
        Busy      = 1'b1;
        Step      = 2'd1;
        state_nxt = ST_T2;
      end
      ST_T2: begin
        rout_idx = src;
        rout_en  = 1'b1;
        SelectY  = 1'b1;
        Add      = (op == OP_ADD);
        Sub      = (op == OP_SUB);
        Mul      = (op == OP_MUL);
        Div      = (op == OP_DIV);
        Zin      = AluDone;
        Busy     = 1'b1;
        Step     = 2'd2;
        if (AluDone)      state_nxt = ST_T3;
        else if (timeout) state_nxt = ST_ABORT;
      end
      ST_T3: begin
        rin_en    = 1'b1;
        Zout      = 1'b1;
        Done      = 1'b1;
        Busy      = 1'b1;
        Step      = 2'd3;
        state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        Error     = 1'b1;
        Busy      = 1'b1;
        Step      = 2'd3;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  cu_onehot_decoder #(.N(NUM_REGS), .W(RSW)) u_dec_regout (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (RegOut)
  );

  cu_onehot_decoder #(.N(NUM_REGS), .W(RSW)) u_dec_regin (
    .idx    (dst),
    .en     (rin_en),
    .onehot (RegIn)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (NUM_REGS=4, WAIT_LIMIT=15).
// Each cycle the expected output vector is queued as stimulus is applied
// and popped for comparison mid-cycle on the falling edge.
module tb_control_sequencer;

  localparam logic [1:0] T_ADD = 2'd0;
  localparam logic [1:0] T_SUB = 2'd1;
  localparam logic [1:0] T_MUL = 2'd2;
  localparam logic [1:0] T_DIV = 2'd3;

  logic       clk = 1'b0;
  logic       rst, start, alu_done;
  logic [5:0] word;
  logic [3:0] reg_in, reg_out;
  logic       add, sub, mul, div, sel_y, y_in, z_in, z_out, busy, done, err;
  logic [1:0] step;
  logic [20:0] obs;

  int total = 0;
  int bad   = 0;
  logic [20:0] sb[$];

  always #5 clk = ~clk;

  control_sequencer #(.NUM_REGS(4), .WAIT_LIMIT(15)) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Start     (start),
    .InstrWord (word),
    .AluDone   (alu_done),
    .RegIn     (reg_in),
    .RegOut    (reg_out),
    .Add       (add),
    .Sub       (sub),
    .Mul       (mul),
    .Div       (div),
    .SelectY   (sel_y),
    .Yin       (y_in),
    .Zin       (z_in),
    .Zout      (z_out),
    .Busy      (busy),
    .Done      (done),
    .Error     (err),
    .Step      (step)
  );

  assign obs = {reg_in, reg_out, add, sub, mul, div, sel_y, y_in, z_in, z_out,
                busy, done, err, step};

  localparam logic [20:0] E_IDLE  = '0;
  localparam logic [20:0] E_ABORT = {4'b0, 4'b0, 4'b0, 4'b0, 3'b101, 2'd3};

  function automatic logic [3:0] alu_oh(input logic [1:0] op);
    case (op)
      T_ADD:   return 4'b1000;
      T_SUB:   return 4'b0100;
      T_MUL:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [20:0] e_t1(input logic [1:0] d);
    return {4'b0, 4'b0001 << d, 4'b0, 4'b0100, 3'b100, 2'd1};
  endfunction

  function automatic logic [20:0] e_t2(input logic [1:0] op, input logic [1:0] s, input logic z);
    return {4'b0, 4'b0001 << s, alu_oh(op), 1'b1, 1'b0, z, 1'b0, 3'b100, 2'd2};
  endfunction

  function automatic logic [20:0] e_t3(input logic [1:0] d);
    return {4'b0001 << d, 4'b0, 4'b0, 4'b0001, 3'b110, 2'd3};
  endfunction

  task automatic drive(input logic r, input logic s, input logic [5:0] w, input logic a);
    rst = r; start = s; word = w; alu_done = a;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    drive(1'b1, 1'b1, 6'b10_11_00, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) drive(1'b1, 1'b1, 6'b10_11_00, 1'b1);
      else       drive(1'b0, 1'b0, 6'b0, 1'b0);
      sb.push_back(E_IDLE);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs !== e) begin $display("FAIL reset c%0d got=%h exp=%h", c, obs, e); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    logic [20:0] e;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, c == 0, {T_ADD, 2'd1, 2'd2}, 1'b1);
      case (c)
        0:       e = E_IDLE;
        1:       e = e_t1(2'd1);
        2:       e = e_t2(T_ADD, 2'd2, 1'b1);
        3:       e = e_t3(2'd1);
        default: e = E_IDLE;
      endcase
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs !== e) begin $display("FAIL add c%0d got=%h exp=%h", c, obs, e); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul_wait();
    logic [20:0] e;
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, c == 0, {T_MUL, 2'd3, 2'd0}, c == 6);
      if (c == 0)      e = E_IDLE;
      else if (c == 1) e = e_t1(2'd3);
      else if (c <= 6) e = e_t2(T_MUL, 2'd0, c == 6);
      else if (c == 7) e = e_t3(2'd3);
      else             e = E_IDLE;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs !== e) begin $display("FAIL mul_wait c%0d got=%h exp=%h", c, obs, e); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout(input logic rescue);
    logic [20:0] e;
    for (int c = 0; c < 19; c++) begin
      drive(1'b0, c == 0, {T_DIV, 2'd2, 2'd1}, rescue && c == 16);
      if (c == 0)       e = E_IDLE;
      else if (c == 1)  e = e_t1(2'd2);
      else if (c <= 16) e = e_t2(T_DIV, 2'd1, rescue && c == 16);
      else if (c == 17) e = rescue ? e_t3(2'd2) : E_ABORT;
      else              e = E_IDLE;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs !== e) begin
        $display("FAIL timeout%0d c%0d got=%h exp=%h", rescue, c, obs, e); bad++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] w[3];
    logic [5:0] cur;
    logic [20:0] e;
    w[0] = {T_ADD, 2'd1, 2'd2};
    w[1] = {T_SUB, 2'd0, 2'd3};
    w[2] = {T_DIV, 2'd3, 2'd3};
    for (int c = 0; c < 13; c++) begin
      drive(1'b0, c < 12, w[c % 3], 1'b1);
      cur = w[(4 * (c / 4)) % 3];
      case (c % 4)
        1:       e = e_t1(cur[3:2]);
        2:       e = e_t2(cur[5:4], cur[1:0], 1'b1);
        3:       e = e_t3(cur[3:2]);
        default: e = E_IDLE;
      endcase
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs !== e) begin $display("FAIL back_to_back c%0d got=%h exp=%h", c, obs, e); bad++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] e;
    for (int c = 0; c < 7; c++) begin
      drive(c == 3, c == 0, {T_MUL, 2'd3, 2'd0}, c == 4);
      if (c == 0)      e = E_IDLE;
      else if (c == 1) e = e_t1(2'd3);
      else if (c <= 3) e = e_t2(T_MUL, 2'd0, 1'b0);
      else             e = E_IDLE;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs !== e) begin $display("FAIL reset_mid c%0d got=%h exp=%h", c, obs, e); bad++; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
